// File: rtl/echo_delay_pkg.sv
// Shared types, constants and saturating arithmetic for the echo/delay line.
package echo_delay_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_DELAY  = 2'd1,
    MODE_ECHO   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  localparam int unsigned DELAY_MIN = 2;
  localparam int unsigned SAT_W     = 32;

  // Signed add clamped to the range of a data_w-bit two's complement value.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             data_w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = $signed((SAT_W'(1) << (data_w - 32'd1)) - SAT_W'(1));
    lo  = ~hi;
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port, no reset.
module delay_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (i_we)    r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data        <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/echo_delay.sv
// Sample-strobed circular delay line with bypass, pure delay and saturating feedback echo.
module echo_delay
  import echo_delay_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned ATTEN_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  delay,
  input  logic [ATTEN_W-1:0] atten,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               primed
);

  localparam int unsigned       DEPTH    = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] FILL_MAX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] D_MIN    = ADDR_W'(DELAY_MIN);

  logic [ADDR_W-1:0] r_iss_ptr;
  logic [ADDR_W-1:0] r_fill;
  logic              r_primed;
  logic              r_s1_valid;
  mode_t             r_s1_mode;
  logic [ATTEN_W-1:0] r_s1_atten;
  logic signed [DATA_W-1:0] r_s1_data;
  logic [ADDR_W-1:0] r_s1_addr;
  logic              r_s1_zero;

  logic [ADDR_W-1:0] w_d;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_fill_nxt;
  logic              w_take;
  logic [DATA_W-1:0] w_rd_data;
  logic signed [DATA_W-1:0] w_dly;
  logic signed [DATA_W-1:0] w_shift;
  logic signed [DATA_W-1:0] w_echo;
  logic signed [DATA_W-1:0] w_wr_data;
  logic signed [DATA_W-1:0] w_out;
  logic              w_we;
  logic              w_s1_fire;

  // Stage 0: effective delay, read address and fill bookkeeping.
  assign w_d        = (delay < D_MIN) ? D_MIN : delay;
  assign w_take     = in_valid & ~flush;
  assign w_rd_addr  = r_iss_ptr - w_d;
  assign w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + ADDR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_ptr  <= '0;
      r_fill     <= '0;
      r_primed   <= 1'b0;
      r_s1_valid <= 1'b0;
    end else if (flush) begin
      r_iss_ptr  <= '0;
      r_fill     <= '0;
      r_primed   <= 1'b0;
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_iss_ptr <= r_iss_ptr + ADDR_W'(1);
        r_fill    <= w_fill_nxt;
        r_primed  <= (w_fill_nxt >= w_d);
      end
    end
  end

  // Sample payload travels with r_s1_valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_s1_mode  <= mode_t'(mode);
      r_s1_atten <= atten;
      r_s1_data  <= $signed(in_data);
      r_s1_addr  <= r_iss_ptr;
      r_s1_zero  <= (r_fill < w_d);
    end
  end

  delay_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_we),
    .i_wr_addr (r_s1_addr),
    .i_wr_data (w_wr_data),
    .i_rd_en   (w_take),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Stage 1: masked history, echo arithmetic and mode select.
  always_comb begin
    w_dly     = r_s1_zero ? '0 : $signed(w_rd_data);
    w_shift   = w_dly >>> r_s1_atten;
    w_echo    = DATA_W'(sat_add(SAT_W'(w_shift), SAT_W'(r_s1_data), DATA_W));
    w_we      = 1'b0;
    w_wr_data = r_s1_data;
    w_out     = r_s1_data;
    case (r_s1_mode)
      MODE_DELAY: begin
        w_we  = r_s1_valid;
        w_out = w_dly;
      end
      MODE_ECHO: begin
        w_we      = r_s1_valid;
        w_wr_data = w_echo;
        w_out     = w_echo;
      end
      default: ;
    endcase
    if (flush) w_we = 1'b0;
  end

  assign w_s1_fire = r_s1_valid & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= w_s1_fire;
      if (w_s1_fire) out_data <= w_out;
    end
  end

  assign primed = r_primed;

endmodule

// File: tb/tb_echo_delay.sv
// Directed self-checking bench for echo_delay (default size plus a 16-deep instance).
module tb_echo_delay;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [8:0] delay = 9'd0;
  logic [2:0] atten = 3'd0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic       out_valid_a, out_valid_b;
  logic [7:0] out_data_a, out_data_b;
  logic       primed_a, primed_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int last_a = 0;
  bit hold_en = 1'b0;

  int obs_a[$];
  int obs_b[$];
  int cyc_a[$];
  int cyc_b[$];
  int in_cyc[$];
  int exp_q[$];

  echo_delay #(.DATA_W(8), .ADDR_W(9), .ATTEN_W(3)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .mode(mode), .delay(delay),
    .atten(atten), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid_a), .out_data(out_data_a), .primed(primed_a)
  );

  echo_delay #(.DATA_W(8), .ADDR_W(4), .ATTEN_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .mode(mode), .delay(delay[3:0]),
    .atten(atten), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid_b), .out_data(out_data_b), .primed(primed_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid_a) begin
      obs_a.push_back(int'($signed(out_data_a)));
      cyc_a.push_back(cyc);
      last_a = int'($signed(out_data_a));
    end else if (hold_en) begin
      chk("hold", int'($signed(out_data_a)), last_a);
    end
    if (out_valid_b) begin
      obs_b.push_back(int'($signed(out_data_b)));
      cyc_b.push_back(cyc);
    end
  end

  task automatic send(input int m, input int d, input int at, input int x);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b1;
    mode     = 2'(m);
    delay    = 9'(d);
    atten    = 3'(at);
    in_data  = 8'(x);
    in_cyc.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  task automatic clear_q();
    obs_a.delete();
    obs_b.delete();
    cyc_a.delete();
    cyc_b.delete();
    in_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_flush();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b1;
    idle(3);
    clear_q();
  endtask

  task automatic check_outs(input string tag, input bit use_b, input bit lat);
    int n;
    n = use_b ? obs_b.size() : obs_a.size();
    chk({tag, " count"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      chk(tag, use_b ? obs_b[i] : obs_a[i], exp_q[i]);
      if (lat && i < in_cyc.size())
        chk({tag, " latency"}, (use_b ? cyc_b[i] : cyc_a[i]) - in_cyc[i], 2);
    end
  endtask

  int gaps[8]  = '{0, 3, 1, 5, 0, 2, 4, 1};
  int bdata[8] = '{10, -20, 30, -40, 50, -60, 70, -80};
  int bmode[8] = '{0, 0, 3, 0, 0, 3, 0, 0};

  initial begin
    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("rst out_valid", int'(out_valid_a), 0);
    chk("rst out_data", int'(out_data_a), 0);
    chk("rst primed", int'(primed_a), 0);
    @(negedge clk) rst = 1'b0;

    // Reset while streaming
    for (int k = 0; k < 4; k++) send(0, 0, 0, 55);
    chk("pre-rst out_valid", int'(out_valid_a), 1);
    chk("pre-rst out_data", int'($signed(out_data_a)), 55);
    chk("pre-rst primed", int'(primed_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid-rst out_valid", int'(out_valid_a), 0);
    chk("mid-rst out_data", int'(out_data_a), 0);
    chk("mid-rst primed", int'(primed_a), 0);
    in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    idle(2);
    clear_q();

    // Delay D=3, ramp 1..10
    for (int k = 1; k <= 10; k++) begin
      send(1, 3, 0, k);
      if (k > 1) chk("ramp primed", int'(primed_a), (k - 1 >= 3) ? 1 : 0);
    end
    idle(1);
    chk("ramp primed", int'(primed_a), 1);
    idle(3);
    exp_q = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7};
    check_outs("delay3", 1'b0, 1'b1);

    // Echo impulse, D=2, atten=1
    do_flush();
    for (int k = 0; k < 15; k++) send(2, 2, 1, (k == 0) ? 64 : 0);
    idle(3);
    exp_q = '{64, 0, 32, 0, 16, 0, 8, 0, 4, 0, 2, 0, 1, 0, 0};
    check_outs("echo impulse", 1'b0, 1'b1);

    // Echo saturation, positive then negative
    do_flush();
    for (int k = 0; k < 6; k++) send(2, 2, 0, 100);
    idle(3);
    exp_q = '{100, 100, 127, 127, 127, 127};
    check_outs("echo sat+", 1'b0, 1'b1);
    do_flush();
    for (int k = 0; k < 6; k++) send(2, 2, 0, -100);
    idle(3);
    exp_q = '{-100, -100, -128, -128, -128, -128};
    check_outs("echo sat-", 1'b0, 1'b1);

    // 16-deep instance: D=15 across pointer wrap
    do_flush();
    for (int k = 0; k < 40; k++) send(1, 15, 0, k);
    idle(3);
    for (int k = 0; k < 40; k++) exp_q.push_back((k < 15) ? 0 : k - 15);
    check_outs("wrap d15", 1'b1, 1'b1);

    // delay 0 and 1 clamp to 2
    for (int d = 0; d < 2; d++) begin
      do_flush();
      for (int k = 0; k < 10; k++) send(1, d, 0, k);
      idle(3);
      for (int k = 0; k < 10; k++) exp_q.push_back((k < 2) ? 0 : k - 2);
      check_outs((d == 0) ? "delay0 clamp" : "delay1 clamp", 1'b1, 1'b1);
    end

    // Bypass (incl. reserved mode) with sparse strobes; output holds between strobes
    do_flush();
    hold_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (gaps[k] > 0) idle(gaps[k]);
      send(bmode[k], 5, 0, bdata[k]);
    end
    idle(4);
    hold_en = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(bdata[k]);
    check_outs("bypass", 1'b0, 1'b1);

    // Flush colliding with sample 11, D=4
    do_flush();
    for (int k = 1; k <= 10; k++) send(1, 4, 0, k);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 8'd11;
    flush    = 1'b1;
    send(1, 4, 0, 101);
    chk("flush primed", int'(primed_a), 0);
    for (int k = 102; k <= 108; k++) send(1, 4, 0, k);
    idle(3);
    exp_q = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 0, 0, 0, 0, 101, 102, 103, 104};
    check_outs("flush", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
